// File: rtl/nv_ram_rwsp_8x257_fifo_ctrl_pkg.sv
// Shared constants and types for the 8x257 RAM-backed FIFO controller.
package nv_fifo_ctrl_pkg;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;
  localparam int unsigned DW    = 257;
  localparam int unsigned CW    = 4;

  typedef logic [DW-1:0] pd_t;
  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

endpackage

// File: rtl/nv_ram_rwsp_8x257_fifo_ctrl_if.sv
// Producer/consumer valid-ready stream bundle around the FIFO controller.
interface nv_ram_rwsp_8x257_fifo_ctrl_if;
  import nv_fifo_ctrl_pkg::*;

  logic wr_pvld;
  logic wr_prdy;
  pd_t  wr_pd;
  logic rd_pvld;
  logic rd_prdy;
  pd_t  rd_pd;

  modport slave (
    input  wr_pvld, wr_pd, rd_prdy,
    output wr_prdy, rd_pvld, rd_pd
  );

  modport master (
    output wr_pvld, wr_pd, rd_prdy,
    input  wr_prdy, rd_pvld, rd_pd
  );

endinterface

// File: rtl/nv_ram_rwsp_8x257_fifo_ctrl.sv
// Sequences an external 8x257 two-port RAM as a 9-entry stream buffer,
// hiding the RAM's address-latch + output-register read pipeline.
module nv_ram_rwsp_8x257_fifo_ctrl
  import nv_fifo_ctrl_pkg::*;
(
  input  logic                               clk,
  input  logic                               rst,
  nv_ram_rwsp_8x257_fifo_ctrl_if.slave       bus,
  output ptr_t                               ram_wa,
  output logic                               ram_we,
  output pd_t                                ram_di,
  output ptr_t                               ram_ra,
  output logic                               ram_re,
  output logic                               ram_ore,
  input  pd_t                                ram_dout,
  output cnt_t                               fifo_cnt,
  input  logic [31:0]                        pwrbus_ram_pd_in,
  output logic [31:0]                        pwrbus_ram_pd
);

  ptr_t wr_ptr;
  ptr_t rd_ptr;
  cnt_t ram_cnt;
  logic s1_vld;
  logic s2_vld;
  logic push;
  logic pop;
  cnt_t unissued;

  // A slot stays counted in ram_cnt until ore copies it out, so the address
  // latch (s1) never needs its own occupancy; unissued excludes it.
  always_comb begin
    bus.wr_prdy   = (ram_cnt != cnt_t'(DEPTH));
    push          = bus.wr_pvld & bus.wr_prdy;
    bus.rd_pvld   = s2_vld;
    bus.rd_pd     = ram_dout;
    pop           = s2_vld & bus.rd_prdy;
    unissued      = ram_cnt - cnt_t'(s1_vld);
    ram_ore       = s1_vld & (~s2_vld | pop);
    ram_re        = (unissued != '0) & (~s1_vld | ram_ore);
    ram_we        = push;
    ram_wa        = wr_ptr;
    ram_di        = bus.wr_pd;
    ram_ra        = rd_ptr;
    fifo_cnt      = ram_cnt + cnt_t'(s2_vld);
    pwrbus_ram_pd = pwrbus_ram_pd_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ram_cnt <= '0;
      s1_vld  <= 1'b0;
      s2_vld  <= 1'b0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + ptr_t'(1);
      if (ram_re) rd_ptr <= rd_ptr + ptr_t'(1);
      ram_cnt <= ram_cnt + cnt_t'(push) - cnt_t'(ram_ore);
      s1_vld  <= ram_re  | (s1_vld & ~ram_ore);
      s2_vld  <= ram_ore | (s2_vld & ~pop);
    end
  end

endmodule
